// File: rtl/mole_game_pkg.sv
// Shared types and constants for the whack-a-mole game engine.
// Holds the game state enum, the LFSR seed/tap mask and the default
// parameter values used by mole_game_core.
package mole_game_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    OVER = 2'd2
  } game_state_t;

  // x^16+x^14+x^13+x^11+1 in right-shift Fibonacci form: the feedback bit is
  // the XOR of register bits 0, 2, 3 and 5 and enters at bit 15.
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'h002D;

  localparam int DEF_N_HOLES       = 8;
  localparam int DEF_SCORE_W       = 8;
  localparam int DEF_GAME_SECONDS  = 30;
  localparam int DEF_TICKS_PER_SEC = 100_000_000;
  localparam int DEF_MOLE_LIFE     = 150_000_000;

endpackage

// File: rtl/lfsr16.sv
// Free-running 16-bit Fibonacci LFSR used as the mole position source.
// Ports: clk, rst_n (async active-low, loads LFSR_SEED), value (full register).
// Advances every clock regardless of game state.
module lfsr16
  import mole_game_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  output logic [15:0] value
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value <= LFSR_SEED;
    end else begin
      value <= {^(value & LFSR_TAPS), value[15:1]};
    end
  end

endmodule

// File: rtl/mole_game_core.sv
// Whack-a-mole game engine: IDLE/PLAY/OVER control, mole placement, scoring,
// countdown and timed-mode mole lifetime. All outputs come from registers.
// Ports: start/mode_timed/penalty_en/guess_valid/guess in; mole_pos, playing,
// game_over, score, seconds and one-cycle hit/miss/expired pulses out.
module mole_game_core
  import mole_game_pkg::*;
#(
  parameter int N_HOLES       = DEF_N_HOLES,
  parameter int POS_W         = $clog2(N_HOLES),
  parameter int SCORE_W       = DEF_SCORE_W,
  parameter int GAME_SECONDS  = DEF_GAME_SECONDS,
  parameter int TICKS_PER_SEC = DEF_TICKS_PER_SEC,
  parameter int MOLE_LIFE     = DEF_MOLE_LIFE
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               mode_timed,
  input  logic               penalty_en,
  input  logic               guess_valid,
  input  logic [POS_W-1:0]   guess,
  output logic [POS_W-1:0]   mole_pos,
  output logic               playing,
  output logic               game_over,
  output logic [SCORE_W-1:0] score,
  output logic [7:0]         seconds,
  output logic               hit,
  output logic               miss,
  output logic               expired
);

  localparam int TICK_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam int LIFE_W = $clog2(MOLE_LIFE);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICKS_PER_SEC - 1);
  localparam logic [LIFE_W-1:0] LIFE_LAST = LIFE_W'(MOLE_LIFE - 1);

  logic [15:0] lfsr;

  lfsr16 u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .value (lfsr)
  );

  game_state_t        state, state_nxt;
  logic [TICK_W-1:0]  tick_cnt, tick_nxt;
  logic [LIFE_W-1:0]  life_cnt, life_nxt;
  logic               timed_q, timed_nxt;
  logic               pen_q, pen_nxt;
  logic [POS_W-1:0]   pos_nxt;
  logic [SCORE_W-1:0] score_nxt;
  logic [7:0]         seconds_nxt;
  logic               hit_nxt, miss_nxt, exp_nxt;
  logic               last_tick, game_end, is_hit, life_up;

  // Next mole hole: LFSR modulo hole count, bumped by one (with wrap) when it
  // would land on the current hole so every move is visible.
  function automatic logic [POS_W-1:0] pick_pos(input logic [15:0] r,
                                                input logic [POS_W-1:0] cur);
    logic [15:0] m;
    m = r % 16'(N_HOLES);
    if (m[POS_W-1:0] == cur) begin
      if (m == 16'(N_HOLES - 1)) return '0;
      return m[POS_W-1:0] + POS_W'(1);
    end
    return m[POS_W-1:0];
  endfunction

  always_comb begin
    state_nxt   = state;
    tick_nxt    = tick_cnt;
    life_nxt    = life_cnt;
    timed_nxt   = timed_q;
    pen_nxt     = pen_q;
    pos_nxt     = mole_pos;
    score_nxt   = score;
    seconds_nxt = seconds;
    hit_nxt     = 1'b0;
    miss_nxt    = 1'b0;
    exp_nxt     = 1'b0;

    last_tick = (tick_cnt == TICK_LAST);
    game_end  = last_tick && (seconds == 8'd1);
    // mole_pos is always below N_HOLES, so an out-of-range guess never matches
    // and falls through to the miss path.
    is_hit    = guess_valid && (guess == mole_pos);
    life_up   = timed_q && (life_cnt == LIFE_LAST);

    if (start) begin
      // Restart takes priority over everything, including a same-cycle guess.
      state_nxt   = PLAY;
      tick_nxt    = '0;
      life_nxt    = '0;
      timed_nxt   = mode_timed;
      pen_nxt     = penalty_en;
      pos_nxt     = pick_pos(lfsr, mole_pos);
      score_nxt   = '0;
      seconds_nxt = 8'(GAME_SECONDS);
    end else if (state == PLAY) begin
      if (game_end) begin
        // Final tick ends the game; guesses and expiries this cycle are dropped.
        state_nxt   = OVER;
        tick_nxt    = '0;
        seconds_nxt = 8'd0;
      end else begin
        if (last_tick) begin
          tick_nxt    = '0;
          seconds_nxt = seconds - 8'd1;
        end else begin
          tick_nxt = tick_cnt + TICK_W'(1);
        end

        if (is_hit) begin
          // A hit absorbs a coincident expiry: one move, no expired pulse.
          hit_nxt  = 1'b1;
          pos_nxt  = pick_pos(lfsr, mole_pos);
          life_nxt = '0;
          if (score != '1) score_nxt = score + SCORE_W'(1);
        end else begin
          if (guess_valid) begin
            miss_nxt = 1'b1;
            if (pen_q && (score != '0)) score_nxt = score - SCORE_W'(1);
          end
          if (life_up) begin
            exp_nxt  = 1'b1;
            pos_nxt  = pick_pos(lfsr, mole_pos);
            life_nxt = '0;
          end else if (timed_q) begin
            life_nxt = life_cnt + LIFE_W'(1);
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      tick_cnt <= '0;
      life_cnt <= '0;
      timed_q  <= 1'b0;
      pen_q    <= 1'b0;
      mole_pos <= '0;
      score    <= '0;
      seconds  <= 8'(GAME_SECONDS);
      hit      <= 1'b0;
      miss     <= 1'b0;
      expired  <= 1'b0;
    end else begin
      state    <= state_nxt;
      tick_cnt <= tick_nxt;
      life_cnt <= life_nxt;
      timed_q  <= timed_nxt;
      pen_q    <= pen_nxt;
      mole_pos <= pos_nxt;
      score    <= score_nxt;
      seconds  <= seconds_nxt;
      hit      <= hit_nxt;
      miss     <= miss_nxt;
      expired  <= exp_nxt;
    end
  end

  assign playing   = (state == PLAY);
  assign game_over = (state == OVER);

endmodule

// File: tb/tb_mole_game_core.sv
// Self-checking bench for mole_game_core with a cycle-level game model.
module tb_mole_game_core;

  localparam int NH  = 8;
  localparam int SW  = 2;
  localparam int GS  = 3;
  localparam int TPS = 4;
  localparam int ML  = 5;
  localparam int SMAX = (1 << SW) - 1;

  localparam int PH_IDLE = 0;
  localparam int PH_PLAY = 1;
  localparam int PH_OVER = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       mode_timed = 1'b0;
  logic       penalty_en = 1'b0;
  logic       guess_valid = 1'b0;
  logic [2:0] guess = 3'd0;
  logic [2:0] mole_pos;
  logic       playing, game_over;
  logic [1:0] score;
  logic [7:0] seconds;
  logic       hit, miss, expired;

  always #5 clk = ~clk;

  mole_game_core #(
    .N_HOLES       (NH),
    .SCORE_W       (SW),
    .GAME_SECONDS  (GS),
    .TICKS_PER_SEC (TPS),
    .MOLE_LIFE     (ML)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .mode_timed  (mode_timed),
    .penalty_en  (penalty_en),
    .guess_valid (guess_valid),
    .guess       (guess),
    .mole_pos    (mole_pos),
    .playing     (playing),
    .game_over   (game_over),
    .score       (score),
    .seconds     (seconds),
    .hit         (hit),
    .miss        (miss),
    .expired     (expired)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference game model: cycles elapsed since the last move/second rather
  // than hardware counters, plus an arithmetic LFSR.
  int          m_phase, m_score, m_sec, m_pos, m_cyc_in_sec, m_cyc_since_move;
  int          m_hit, m_miss, m_exp;
  bit          m_timed, m_pen;
  int unsigned m_lfsr;

  function automatic int unsigned lfsr_step(input int unsigned l);
    int unsigned b;
    b = ((l >> 0) ^ (l >> 2) ^ (l >> 3) ^ (l >> 5)) & 32'd1;
    return (l >> 1) | (b << 15);
  endfunction

  function automatic int relocate(input int unsigned l, input int cur);
    int p;
    p = int'(l % NH);
    if (p == cur) p = (p + 1) % NH;
    return p;
  endfunction

  task automatic model_reset();
    m_phase = PH_IDLE; m_score = 0; m_sec = GS; m_pos = 0;
    m_cyc_in_sec = 0; m_cyc_since_move = 0;
    m_hit = 0; m_miss = 0; m_exp = 0;
    m_timed = 0; m_pen = 0;
    m_lfsr = 32'hACE1;
  endtask

  task automatic model_step(input bit s, input bit t, input bit p,
                            input bit gv, input int g);
    m_hit = 0; m_miss = 0; m_exp = 0;
    if (s) begin
      m_phase = PH_PLAY; m_score = 0; m_sec = GS;
      m_cyc_in_sec = 0; m_cyc_since_move = 0;
      m_timed = t; m_pen = p;
      m_pos = relocate(m_lfsr, m_pos);
    end else if (m_phase == PH_PLAY) begin
      m_cyc_in_sec++;
      m_cyc_since_move++;
      if (m_cyc_in_sec == TPS && m_sec == 1) begin
        m_phase = PH_OVER; m_sec = 0;
      end else begin
        if (m_cyc_in_sec == TPS) begin
          m_cyc_in_sec = 0; m_sec--;
        end
        if (gv && g == m_pos) begin
          m_hit = 1;
          m_score = (m_score < SMAX) ? m_score + 1 : SMAX;
          m_pos = relocate(m_lfsr, m_pos);
          m_cyc_since_move = 0;
        end else begin
          if (gv) begin
            m_miss = 1;
            if (m_pen && m_score > 0) m_score--;
          end
          if (m_timed && m_cyc_since_move == ML) begin
            m_exp = 1;
            m_pos = relocate(m_lfsr, m_pos);
            m_cyc_since_move = 0;
          end
        end
      end
    end
    m_lfsr = lfsr_step(m_lfsr);
  endtask

  task automatic compare_all();
    check("mole_pos",  mole_pos,  m_pos);
    check("playing",   playing,   int'(m_phase == PH_PLAY));
    check("game_over", game_over, int'(m_phase == PH_OVER));
    check("score",     score,     m_score);
    check("seconds",   seconds,   m_sec);
    check("hit",       hit,       m_hit);
    check("miss",      miss,      m_miss);
    check("expired",   expired,   m_exp);
  endtask

  // One clock: drive inputs, step the model with them at the edge, compare.
  task automatic cycle(input bit s, input bit t, input bit p,
                       input bit gv, input int g);
    start = s; mode_timed = t; penalty_en = p; guess_valid = gv; guess = 3'(g);
    @(posedge clk);
    model_step(s, t, p, gv, g);
    #1;
    compare_all();
    start = 1'b0; guess_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) cycle(0, 0, 0, 0, 0);
  endtask

  int old_pos;

  initial begin
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    model_reset();
    compare_all();
    check("rst_playing", playing, 0);
    check("rst_seconds", seconds, GS);
    rst_n = 1'b1;

    // Full game with no guesses, then a guess in OVER.
    cycle(1, 0, 0, 0, 0);
    check("start_playing", playing, 1);
    check("start_score", score, 0);
    check("start_seconds", seconds, GS);
    idle(11);
    check("not_over_yet", game_over, 0);
    idle(1);
    check("over_after_12", game_over, 1);
    check("over_seconds", seconds, 0);
    cycle(0, 0, 0, 1, m_pos);
    check("over_guess_hit", hit, 0);
    check("over_guess_miss", miss, 0);

    // Classic mode hit then miss.
    cycle(1, 0, 0, 0, 0);
    old_pos = mole_pos;
    cycle(0, 0, 0, 1, m_pos);
    check("classic_hit", hit, 1);
    check("classic_hit_score", score, 1);
    check("classic_moved", int'(mole_pos != 3'(old_pos)), 1);
    old_pos = mole_pos;
    cycle(0, 0, 0, 1, (m_pos + 1) % NH);
    check("classic_miss", miss, 1);
    check("classic_miss_score", score, 1);
    check("classic_miss_stays", int'(mole_pos == 3'(old_pos)), 1);

    // Penalty mode with floor at zero.
    cycle(1, 0, 1, 0, 0);
    cycle(0, 0, 0, 1, m_pos);
    check("pen_hit_score", score, 1);
    cycle(0, 0, 0, 1, (m_pos + 1) % NH);
    check("pen_miss_score", score, 0);
    cycle(0, 0, 0, 1, (m_pos + 1) % NH);
    check("pen_floor_miss", miss, 1);
    check("pen_floor_score", score, 0);

    // Timed mode, no guesses: expiry every ML cycles.
    cycle(1, 1, 0, 0, 0);
    for (int i = 1; i <= 11; i++) begin
      old_pos = mole_pos;
      idle(1);
      check("timed_expired", expired, int'(i % ML == 0));
      check("timed_pos_changed", int'(mole_pos != 3'(old_pos)), int'(i % ML == 0));
    end
    check("timed_score", score, 0);

    // Timed mode, correct guess on the expiry cycle.
    cycle(1, 1, 0, 0, 0);
    idle(ML - 1);
    old_pos = mole_pos;
    cycle(0, 0, 0, 1, m_pos);
    check("hitexp_hit", hit, 1);
    check("hitexp_expired", expired, 0);
    check("hitexp_score", score, 1);
    check("hitexp_moved", int'(mole_pos != 3'(old_pos)), 1);
    idle(ML - 1);
    check("hitexp_no_early_exp", expired, 0);
    idle(1);
    check("hitexp_next_exp", expired, 1);

    // Score saturation at 2^SW-1.
    cycle(1, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) cycle(0, 0, 0, 1, m_pos);
    check("sat_score", score, SMAX);
    check("sat_hit", hit, 1);

    // Restart with a coincident guess: restart wins.
    cycle(1, 0, 0, 1, m_pos);
    check("restart_score", score, 0);
    check("restart_seconds", seconds, GS);
    check("restart_hit", hit, 0);

    // Randomised play.
    for (int i = 0; i < 600; i++) begin
      bit s, t, p, gv;
      int g;
      s  = ($urandom_range(0, 29) == 0);
      t  = 1'($urandom_range(0, 1));
      p  = 1'($urandom_range(0, 1));
      gv = ($urandom_range(0, 2) != 0);
      g  = ($urandom_range(0, 1) == 1) ? m_pos : int'($urandom_range(0, NH - 1));
      cycle(s, t, p, gv, g);
    end

    // Asynchronous reset mid-game, between edges.
    cycle(1, 1, 1, 0, 0);
    cycle(0, 0, 0, 1, m_pos);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    compare_all();
    check("async_rst_playing", playing, 0);
    check("async_rst_score", score, 0);
    check("async_rst_hit", hit, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cycle(1, 0, 0, 0, 0);
    cycle(0, 0, 0, 1, m_pos);
    check("post_rst_hit", hit, 1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mole_game_core.md
# mole_game_core

Parametrised game engine for the whack-a-mole design. Replaces the fixed 8-hole, score-on-hit-only wiring between mole positioning, scoring and countdown with a single block. Hole count, score width, game length and tick rate are set by parameters. Adds a timed mode in which an unhit mole relocates after a lifetime expires, plus an optional miss penalty. Sits between the debounced input block (guess strobes) and the LED/seven-segment/VGA display blocks (position, score, seconds, event pulses).

## Interface

Parameters
- N_HOLES, 8: number of mole positions; legal range 2..256.
- POS_W, $clog2(N_HOLES): position width; derived, do not override.
- SCORE_W, 8: score width.
- GAME_SECONDS, 30: countdown start value; legal range 1..255.
- TICKS_PER_SEC, 100_000_000: clk cycles per game second.
- MOLE_LIFE, 150_000_000: clk cycles a mole stays up in timed mode; minimum 2.

Ports
- clk, in, 1: system clock.
- rst_n, in, 1: reset. Asynchronous assert, active-low.
- start, in, 1: single-cycle strobe that starts or restarts a game.
- mode_timed, in, 1: 1 = mole relocates on lifetime expiry. Sampled only on start.
- penalty_en, in, 1: 1 = a wrong guess decrements score. Sampled only on start.
- guess_valid, in, 1: single-cycle guess strobe.
- guess, in, POS_W: guessed hole.
- mole_pos, out, POS_W: current mole hole.
- playing, out, 1: high in PLAY.
- game_over, out, 1: high in OVER.
- score, out, SCORE_W: current score.
- seconds, out, 8: seconds remaining.
- hit, out, 1: one-cycle pulse on a correct guess.
- miss, out, 1: one-cycle pulse on a wrong guess.
- expired, out, 1: one-cycle pulse on a timed-mode relocation.

## Operation

- States are IDLE, PLAY and OVER.
- Transitions:
  - IDLE→PLAY on start.
  - PLAY→OVER on the final second tick.
  - OVER→PLAY on start.
  - start in PLAY restarts the game.
  - There is no path back to IDLE except reset.
- On entering PLAY (restart included):
  - score=0, seconds=GAME_SECONDS.
  - Tick and life counters clear.
  - mode_timed and penalty_en are latched.
  - mole_pos loads a new position.
- The 16-bit LFSR is free-running from reset in every state.
  - Polynomial x^16+x^14+x^13+x^11+1, seed 16'hACE1.
- New position = lfsr % N_HOLES. If that equals the current mole_pos, use (value+1) wrapped to 0 at N_HOLES. The mole never reappears in the same hole on a move.
- Guesses are evaluated only in PLAY; a guess in any other state is ignored.
  - Guess == mole_pos: hit. score+1, saturating at 2^SCORE_W-1. Mole moves. Life counter clears.
  - Guess != mole_pos: miss. If the latched penalty_en is set, score-1 with a floor of 0. Mole stays.
  - guess ≥ N_HOLES always counts as a miss.
- Timed mode: the life counter counts PLAY cycles. When it reaches MOLE_LIFE-1:
  - the mole moves,
  - expired pulses,
  - the counter clears.
  - Score is unchanged.
- Tick counter: wraps at TICKS_PER_SEC-1, and seconds decrements at each wrap. The wrap that takes seconds from 1 to 0 enters OVER.
- In OVER, mole_pos, score and seconds hold their values.
- Simultaneous events in the same cycle:
  - Hit and expiry: the hit wins. One move, hit pulses, expired does not.
  - Miss and expiry: both pulses; the expiry move happens.
  - Guess on the final tick: the game ends and the guess is ignored (no pulse, no score change).
  - start and guess_valid: restart wins and the guess is ignored.

## Timing

- Reset values:
  - state IDLE, playing=0, game_over=0.
  - score=0, seconds=GAME_SECONDS, mole_pos=0.
  - hit=miss=expired=0, LFSR=seed.
- start sampled at edge k gives playing=1, new mole_pos and reset score/seconds visible after edge k.
- guess_valid sampled at edge k gives hit or miss high for exactly the cycle after edge k. The updated score and mole_pos are visible in that same cycle. Latency is 1.
- The first seconds decrement occurs TICKS_PER_SEC cycles after entering PLAY.
- game_over asserts after GAME_SECONDS×TICKS_PER_SEC cycles of PLAY.
- An expiry move occurs MOLE_LIFE cycles after the previous move, if no hit intervenes.
- All outputs are registered. No combinational input-to-output path.

## Structure

- Package mole_game_pkg holds:
  - the state enum (IDLE, PLAY, OVER),
  - LFSR_SEED and LFSR taps,
  - the default parameter constants.
- Sub-module lfsr16: free-running 16-bit Fibonacci LFSR with async active-low reset. Output is the full register.
- Everything else lives in the core. Display digit splitting stays in the top level.

## Test plan

Bench parameters: N_HOLES=8, TICKS_PER_SEC=4, GAME_SECONDS=3, MOLE_LIFE=5.

- Reset, then start: playing=1, score=0, seconds=3. After 12 cycles, game_over=1 and seconds=0. A later guess produces no pulses.
- Classic mode:
  - guess=mole_pos gives hit after 1 cycle, score=1, and a new mole_pos ≠ old.
  - A wrong guess gives miss with score unchanged.
  - With penalty_en=1, score 1→0; a second miss leaves score=0 (floor).
- Timed mode, no guesses: expired pulses every 5 cycles, mole_pos changes every time, score stays 0.
- Timed mode, correct guess on the expiry cycle: hit=1, expired=0, a single move, score+1.
- SCORE_W=2: four hits give score saturated at 3.
- Mid-game:
  - start restarts with score=0, seconds=3.
  - Asserting rst_n low between edges clears all outputs immediately.
